// File: rtl/apb_master.sv
// apb_master: turns a valid/ready command into one APB transfer, aborting a
//   transfer whose ACCESS phase waits TIMEOUT_CYCLES cycles without PREADY.
// Latency: accept in N, SETUP N+1, ACCESS N+2.., rsp_valid on the cycle after
//   the completing (or timing-out) ACCESS cycle.
// Backpressure: cmd_ready only in IDLE or on a completing ACCESS cycle;
//   rsp_valid is a one-cycle pulse with no backpressure.
// Ports:
//   PCLK, PRESETn                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake; cmd_write, cmd_addr, cmd_wdata
//   rsp_valid, rsp_rdata, rsp_err  completion pulse, read data, timeout flag
//   PSEL, PENABLE, PWRITE, PADDR, PWRDATA  registered APB request
//   PRDATA, PREADY                 APB completer response
module apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWRDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  // The timeout fires on the wait cycle that would bring the counter to
  // TIMEOUT_CYCLES, so compare against one less than the limit.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]            r_state;
  logic [7:0]            r_wait_cnt;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_is_idle;
  logic                  w_is_access;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_cmd_ready;
  logic                  w_accept;
  logic [1:0]            w_state_nxt;

  assign w_is_idle   = (r_state == S_IDLE);
  assign w_is_access = (r_state == S_ACCESS);
  assign w_done      = w_is_access && PREADY;
  // PREADY on the last allowed cycle wins over the timeout.
  assign w_timeout   = w_is_access && !PREADY && (r_wait_cnt == TO_LAST);
  // Gated by PRESETn so the handshake is closed while reset is held.
  assign w_cmd_ready = PRESETn && (w_is_idle || w_done);
  assign w_accept    = cmd_valid && w_cmd_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (w_done)         w_state_nxt = w_accept ? S_SETUP : S_IDLE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      // Bus control is decoded from the next state so it leaves a flop.
      r_psel    <= (w_state_nxt != S_IDLE);
      r_penable <= (w_state_nxt == S_ACCESS);

      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end

      if (r_state == S_SETUP) begin
        r_wait_cnt <= '0;
      end else if (w_is_access && !PREADY) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end

      r_rsp_valid <= w_done || w_timeout;
      if (w_done) begin
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
      end else if (w_timeout) begin
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWRDATA   = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized and directed transfers against a queue-based model.
// Commands are pushed to a slave queue and an expected-response queue on
// acceptance; a separate monitor pops expected responses on rsp_valid.
module tb_apb_master;

  localparam int T = 16;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          acc_cyc;
    int          lat;
  } exp_t;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWRDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWRDATA(PWRDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  txn_t slv_q[$];
  exp_t exp_q[$];

  logic [31:0] last_rdata = '0;
  bit          last_err = 1'b0;
  bit          to_cyc = 1'b0;
  bit          done_cyc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Completer model: picks up the next queued transfer at SETUP, holds PREADY
  // low for the chosen number of wait cycles, then returns the chosen data.
  initial begin
    txn_t cur;
    bit   have = 1'b0;
    int   n = 0;
    PREADY = 1'b0;
    PRDATA = '0;
    forever begin
      @(posedge PCLK);
      #1;
      to_cyc   = 1'b0;
      done_cyc = 1'b0;
      if (PSEL && !PENABLE) begin
        if (slv_q.size() == 0) begin
          chk("slave_unexpected_setup", 1, 0);
          have = 1'b0;
        end else begin
          cur  = slv_q.pop_front();
          have = 1'b1;
          n    = 0;
          chk("setup_paddr", PADDR, cur.addr);
          chk("setup_pwrite", PWRITE, cur.wr);
          chk("setup_pwdata", PWRDATA, cur.wdata);
        end
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
      end else if (PSEL && PENABLE && have) begin
        chk("access_paddr_stable", PADDR, cur.addr);
        chk("access_pwrite_stable", PWRITE, cur.wr);
        chk("access_pwdata_stable", PWRDATA, cur.wdata);
        if (n >= T) chk("access_overrun", n, T - 1);
        PREADY = (n == cur.waits);
        PRDATA = PREADY ? cur.rdata : $urandom;
        if (PREADY) done_cyc = 1'b1;
        else if (n == T - 1) to_cyc = 1'b1;
        n++;
      end else begin
        // Outside ACCESS the completer signals are don't-care.
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
      end
    end
  end

  // Response monitor and scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESETn) begin
        if (to_cyc)   chk("cmd_ready_on_timeout", cmd_ready, 0);
        if (done_cyc) chk("cmd_ready_on_done", cmd_ready, 1);
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_latency", cyc - e.acc_cyc, e.lat);
            last_rdata = e.rdata;
            last_err   = e.err;
          end
        end else begin
          chk("rsp_hold", {rsp_err, rsp_rdata}, {last_err, last_rdata});
        end
      end
    end
  end

  task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input logic [31:0] rd);
    int   budget = 0;
    bit   ok = 1'b0;
    txn_t t;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!ok && budget < 200) begin
      @(negedge PCLK);
      if (cmd_ready) ok = 1'b1;
      else budget++;
    end
    if (!ok) begin
      chk("cmd_accept_budget", 0, 1);
    end else begin
      t.wr = wr; t.addr = a; t.wdata = d; t.rdata = rd; t.waits = waits;
      slv_q.push_back(t);
      e.err     = (waits >= T);
      e.rdata   = e.err ? 32'h0 : (wr ? 32'h0 : rd);
      e.acc_cyc = cyc;
      e.lat     = e.err ? T + 2 : waits + 3;
      exp_q.push_back(e);
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input logic [31:0] rd, input int gap);
    send(wr, a, d, waits, rd);
    if (gap > 0) begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      repeat (gap) begin
        @(posedge PCLK);
        #1;
      end
    end
  endtask

  task automatic drain(input string name);
    int budget = 0;
    cmd_valid = 1'b0;
    while (exp_q.size() != 0 && budget < 300) begin
      @(posedge PCLK);
      #1;
      budget++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int w;
    int r;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset_outputs", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready}, 0);
    chk("reset_paddr", PADDR, 0);
    chk("reset_pwdata", PWRDATA, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("cmd_ready_after_reset", cmd_ready, 1);
    @(posedge PCLK);
    #1;

    // Zero-wait write, 3-wait read, back-to-back pair, timeout and last-cycle ready.
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0BAD0BAD, 2);
    xfer(1'b0, 32'h04, 32'h0, 3, 32'h12345678, 2);
    xfer(1'b1, 32'h100, 32'hA5A5A5A5, 0, 32'h0, 0);
    xfer(1'b0, 32'h104, 32'h0, 0, 32'hCAFEF00D, 2);
    xfer(1'b0, 32'h20, 32'h0, T, 32'h55555555, 2);
    xfer(1'b0, 32'h24, 32'h0, T - 1, 32'h66AA66AA, 2);
    xfer(1'b1, 32'h28, 32'h77, T + 3, 32'h0, 0);
    xfer(1'b0, 32'h2C, 32'h0, 1, 32'h89ABCDEF, 1);
    drain("drain_directed");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      w = T - 1;
      else if (r == 1) w = T + $urandom_range(0, 2);
      else             w = $urandom_range(0, 3);
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, w, $urandom, $urandom_range(0, 2));
    end
    drain("drain_random");

    // Reset while the completer is holding off ACCESS.
    send(1'b0, 32'h40, 32'h0, T + 10, 32'hFFFFFFFF);
    cmd_valid = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("pre_reset_in_access", {PSEL, PENABLE}, 2'b11);
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("cmd_ready_in_reset", cmd_ready, 0);
    @(posedge PCLK);
    #1;
    slv_q.delete();
    exp_q.delete();
    last_rdata = '0;
    last_err   = 1'b0;
    @(negedge PCLK);
    chk("abort_outputs", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready}, 0);
    chk("abort_paddr", PADDR, 0);
    chk("abort_pwdata", PWRDATA, 0);
    chk("abort_rsp_rdata", rsp_rdata, 0);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("abort_no_rsp", rsp_valid, 0);
    chk("cmd_ready_after_abort", cmd_ready, 1);
    @(posedge PCLK);
    #1;
    xfer(1'b0, 32'h44, 32'h0, 2, 32'h31415926, 1);
    xfer(1'b1, 32'h48, 32'h27182818, 0, 32'h0, 1);
    drain("drain_after_reset");

    repeat (3) @(posedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
